data_mem_lsu: RTL
=================

// Module: data_mem_lsu
// PURPOSE
//  Load/store initiator between the core datapath and data_mem. Converts
//  RISC-V byte/half/word loads and stores into word-aligned memory requests
//  with byte enables, and sign- or zero-extends read data. Stalls the core
//  until the memory completes the request. Reports misaligned accesses,
//  illegal sizes and bus timeouts.
// PARAMETERS
//  TIMEOUT  16  WAIT cycles without mem_ready before the access aborts (>=2)
// PORTS
//  clk         in   1   single clock, all flops on rising edge
//  rst         in   1   synchronous, active-high reset
//  core_req    in   1   load/store request; held stable while core_stall=1
//  core_we     in   1   1=store, 0=load
//  core_size   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  core_addr   in   32  byte address
//  core_wd     in   32  store data, right-aligned
//  core_rd     out  32  load result, extended to 32 bits
//  core_stall  out  1   freeze core this cycle
//  misalign    out  1   1-cycle pulse: misaligned access dropped
//  illegal     out  1   1-cycle pulse: illegal size (011,110,111; 1xx on store)
//  bus_err     out  1   1-cycle pulse: TIMEOUT reached
//  mem_req     out  1   memory request
//  mem_we      out  1   memory write enable
//  mem_be      out  4   byte enables, bit i = byte lane i
//  mem_addr    out  32  {core_addr[31:2],2'b00}
//  mem_wd      out  32  lane-replicated store data
//  mem_rd      in   32  memory read word
//  mem_ready   in   1   request completed this cycle (rd valid if load)
// BEHAVIOUR
//  FSM: IDLE, WAIT. Reset -> IDLE; outputs 0; rd_q=0; timeout counter=0.
//  IDLE, core_req, aligned and legal: mem_req=1 in the same cycle, offset
//   and size latched, core_stall=1, next state WAIT.
//  IDLE, misaligned (H: addr[0]!=0; W: addr[1:0]!=0): no mem_req, no stall,
//   misalign=1. Illegal size: same, with illegal=1. Misalign has priority.
//  WAIT: mem_req=1 with mem_we/mem_be/mem_addr/mem_wd driven from the held
//   core inputs. core_stall=!mem_ready. On mem_ready -> IDLE and rd_q takes
//   the extracted value.
//  core_rd = extracted(mem_rd) in the WAIT&&mem_ready cycle, else rd_q.
//   Stores leave rd_q unchanged.
//  Counter increments each WAIT cycle. On reaching TIMEOUT without ready:
//   bus_err=1, core_stall=0, mem_req=0, -> IDLE. The counter clears on
//   entry to WAIT.
//  mem_ready in the TIMEOUT cycle itself: completion wins, no bus_err.
//  mem_ready while IDLE is ignored.
//  Byte enables: B 0001<<addr[1:0]; H addr[1]?1100:0011; W 1111.
//  Store data: B {4{wd[7:0]}}, H {2{wd[15:0]}}, W wd.
//  Load extract: select lane by latched offset; B/H sign-extend, BU/HU
//   zero-extend.
//  Reset in WAIT: IDLE on the next edge; mem_req/stall drop; no error pulse.
// STRUCTURE
//  lsu_pkg: funct3 size constants (LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU)
//   and the FSM state enum.
//  Sub-module lsu_align (combinational): be/wd generation, load extraction.
// TESTING (memory model with programmable ready latency L)
//  1 SW 0xDEADBEEF@0x10, then LW@0x10, L=1 -> be=1111, core_rd=0xDEADBEEF,
//    each op stalls exactly 1 cycle.
//  2 SB 0xA5@0x13 -> be=1000, mem_wd=0xA5A5A5A5; LB@0x13 -> 0xFFFFFFA5;
//    LBU@0x13 -> 0x000000A5.
//  3 SH 0x8001@0x16 -> be=1100; LH@0x16 -> 0xFFFF8001; LHU@0x16 -> 0x00008001.
//  4 LW@0x12 -> misalign pulse 1 cycle, mem_req=0, stall=0. Size 011 ->
//    illegal pulse.
//  5 TIMEOUT=16, ready never asserted -> bus_err in the 16th WAIT cycle,
//    stall drops, next req accepted. Ready in the 16th cycle -> no bus_err.
//  6 rst during WAIT -> next cycle mem_req=0, stall=0, core_rd=0. Then 1021
//    random word writes and readbacks with random L in 1..4 -> zero mismatches.

Source files
------------

// File: rtl/data_mem_lsu_pkg.sv
// lsu_pkg: shared definitions for the data-memory load/store unit.
//   - funct3 access-size encodings (LDST_*)
//   - FSM state type
//   - size legality helper
package lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } lsu_state_e;

   // Unsigned variants only make sense for loads.
   function automatic logic size_legal(input logic [2:0] size, input logic we);
      logic ok;
      ok = 1'b0;
      case (size)
         LDST_B, LDST_H, LDST_W: ok = 1'b1;
         LDST_BU, LDST_HU:       ok = !we;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: word-oriented data memory bus.
//   req/we/be/addr/wd : initiator -> memory
//   rd/ready          : memory -> initiator (ready = request completes this cycle)
// Modports: master (load/store unit), slave (memory).
interface data_mem_lsu_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        ready;

   modport master (output req, we, be, addr, wd, input rd, ready);
   modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/data_mem_lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
//   i_size, i_off, i_wd -> o_be, o_wd : byte enables and lane-replicated store data
//   i_ld_size, i_ld_off, i_rd -> o_rd : lane select and sign/zero extension of a load
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wd,
   input  logic [2:0]  i_ld_size,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rd,
   output logic [3:0]  o_be,
   output logic [31:0] o_wd,
   output logic [31:0] o_rd
);

   logic [31:0] w_shift;

   always_comb begin
      o_be = 4'b1111;
      o_wd = i_wd;
      case (i_size[1:0])
         2'b00: begin
            o_be = 4'b0001 << i_off;
            o_wd = {4{i_wd[7:0]}};
         end
         2'b01: begin
            o_be = i_off[1] ? 4'b1100 : 4'b0011;
            o_wd = {2{i_wd[15:0]}};
         end
         default: begin
            o_be = 4'b1111;
            o_wd = i_wd;
         end
      endcase
   end

   assign w_shift = i_rd >> {i_ld_off, 3'b000};

   always_comb begin
      o_rd = i_rd;
      case (i_ld_size)
         LDST_B:  o_rd = {{24{w_shift[7]}}, w_shift[7:0]};
         LDST_BU: o_rd = {24'h0, w_shift[7:0]};
         LDST_H:  o_rd = {{16{w_shift[15]}}, w_shift[15:0]};
         LDST_HU: o_rd = {16'h0, w_shift[15:0]};
         default: o_rd = i_rd;
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator between the core datapath and data memory.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_core_req/we/size/addr/wd : core access request (held while o_core_stall)
//   o_core_rd            : extended load result
//   o_core_stall         : freeze the core this cycle
//   o_misalign/o_illegal/o_bus_err : single-cycle error pulses
//   mem                  : data memory bus (master side)
//
// state   | meaning
// IDLE    | no access outstanding; new requests decoded and launched
// WAIT    | request on the bus, waiting for ready or timeout
module data_mem_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_core_req,
   input  logic                 i_core_we,
   input  logic [2:0]           i_core_size,
   input  logic [31:0]          i_core_addr,
   input  logic [31:0]          i_core_wd,
   output logic [31:0]          o_core_rd,
   output logic                 o_core_stall,
   output logic                 o_misalign,
   output logic                 o_illegal,
   output logic                 o_bus_err,
   data_mem_lsu_if.master       mem
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   lsu_state_e    r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_off;
   logic [2:0]    r_size;
   logic          r_we;
   logic [31:0]   r_rd_q;

   logic          w_is_h;
   logic          w_is_w;
   logic          w_misalign;
   logic          w_legal;
   logic          w_idle_req;
   logic          w_accept;
   logic          w_in_wait;
   logic          w_done;
   logic          w_timeout;
   logic [3:0]    w_be;
   logic [31:0]   w_wd;
   logic [31:0]   w_ext;

   lsu_align u_align (
      .i_size    (i_core_size),
      .i_off     (i_core_addr[1:0]),
      .i_wd      (i_core_wd),
      .i_ld_size (r_size),
      .i_ld_off  (r_off),
      .i_rd      (mem.rd),
      .o_be      (w_be),
      .o_wd      (w_wd),
      .o_rd      (w_ext)
   );

   // Halfword alignment applies to both H and HU so a misaligned HU store
   // reports misalign rather than illegal.
   assign w_is_h     = (i_core_size[1:0] == 2'b01);
   assign w_is_w     = (i_core_size == LDST_W);
   assign w_misalign = (w_is_h && i_core_addr[0]) ||
                       (w_is_w && (i_core_addr[1:0] != 2'b00));
   assign w_legal    = size_legal(i_core_size, i_core_we);

   assign w_idle_req = (r_state == ST_IDLE) && i_core_req;
   assign w_accept   = w_idle_req && !w_misalign && w_legal;
   assign w_in_wait  = (r_state == ST_WAIT);
   assign w_done     = w_in_wait && mem.ready;
   // Completion in the last allowed cycle wins over the timeout.
   assign w_timeout  = w_in_wait && !mem.ready && (r_cnt == CW'(TIMEOUT - 1));

   assign mem.req  = w_accept || (w_in_wait && !w_timeout);
   assign mem.we   = mem.req && i_core_we;
   assign mem.be   = w_be;
   assign mem.addr = {i_core_addr[31:2], 2'b00};
   assign mem.wd   = w_wd;

   assign o_core_stall = w_accept || (w_in_wait && !mem.ready && !w_timeout);
   assign o_core_rd    = w_done ? w_ext : r_rd_q;

   // Error pulses are suppressed while reset is applied.
   assign o_misalign = w_idle_req && w_misalign && !i_rst;
   assign o_illegal  = w_idle_req && !w_misalign && !w_legal && !i_rst;
   assign o_bus_err  = w_timeout && !i_rst;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_off   <= 2'b00;
         r_size  <= 3'b000;
         r_we    <= 1'b0;
         r_rd_q  <= 32'h0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= '0;
                  r_off   <= i_core_addr[1:0];
                  r_size  <= i_core_size;
                  r_we    <= i_core_we;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               if (mem.ready) begin
                  r_state <= ST_IDLE;
                  if (!r_we) r_rd_q <= w_ext;
               end else if (w_timeout) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
